// File: rtl/cp0_reg_pkg.sv
// ----------------------------------------------------------------------------
// cp0_reg_pkg
// Shared constants for the coprocessor-0 register file:
//   - CP0 register addresses (CP0_REG_COUNT ... CP0_REG_BADVADDR)
//   - excepttype_i encodings coming from the MEM stage
//   - ExcCode values written into Cause[6:2]
//   - Status / Cause bit positions
//   - decode_exc(): maps an excepttype word to {valid, ExcCode}
// Optional feature macro: CP0_BADVADDR_EN (adds AdEL/AdES decoding).
// ----------------------------------------------------------------------------
package cp0_reg_pkg;

    // Register addresses
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    // excepttype_i encodings
    localparam logic [31:0] EXC_TYPE_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL     = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES     = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_RI       = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV       = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_TYPE_ERET     = 32'h0000_000e;

    // ExcCode values
    localparam logic [4:0] EXCCODE_INT     = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL    = 5'h04;
    localparam logic [4:0] EXCCODE_ADES    = 5'h05;
    localparam logic [4:0] EXCCODE_SYSCALL = 5'h08;
    localparam logic [4:0] EXCCODE_RI      = 5'h0a;
    localparam logic [4:0] EXCCODE_OV      = 5'h0c;
    localparam logic [4:0] EXCCODE_TRAP    = 5'h0d;

    // Status bit positions
    localparam int STATUS_EXL = 1;
    localparam int STATUS_CU0 = 28;

    // Cause bit positions
    localparam int CAUSE_BD        = 31;
    localparam int CAUSE_IV        = 23;
    localparam int CAUSE_WP        = 22;
    localparam int CAUSE_IP_HW_HI  = 15;
    localparam int CAUSE_IP_HW_LO  = 10;
    localparam int CAUSE_IP_SW_HI  = 9;
    localparam int CAUSE_IP_SW_LO  = 8;
    localparam int CAUSE_EXC_HI    = 6;
    localparam int CAUSE_EXC_LO    = 2;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exc_dec_t;

    // Exceptions that record state (EXL/ExcCode/EPC/BD). eret is not one
    // of them and is handled separately by the caller.
    function automatic exc_dec_t decode_exc(input logic [31:0] etype);
        exc_dec_t d;
        d.valid = 1'b1;
        d.code  = 5'h00;
        case (etype)
            EXC_TYPE_INT:     d.code = EXCCODE_INT;
            EXC_TYPE_SYSCALL: d.code = EXCCODE_SYSCALL;
            EXC_TYPE_RI:      d.code = EXCCODE_RI;
            EXC_TYPE_OV:      d.code = EXCCODE_OV;
            EXC_TYPE_TRAP:    d.code = EXCCODE_TRAP;
`ifdef CP0_BADVADDR_EN
            EXC_TYPE_ADEL:    d.code = EXCCODE_ADEL;
            EXC_TYPE_ADES:    d.code = EXCCODE_ADES;
`endif
            default:          d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// ----------------------------------------------------------------------------
// cp0_reg
// Coprocessor-0 register file sitting after the MEM/WB register.
// Holds Count/Compare/Status/Cause/EPC (+ constant Config/PRId), raises the
// timer interrupt and records exception state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   we_i/waddr_i/data_i       mtc0 write-back triple from WB
//   raddr_i -> data_o         combinational mfc0 read (unimplemented -> 0)
//   int_i[5:0]                hardware interrupt lines, copied to Cause[15:10]
//   excepttype_i              exception summary from MEM
//   current_inst_addr_i       PC of the excepting instruction
//   is_in_delayslot_i         excepting instruction sits in a delay slot
//   badvaddr_i                (CP0_BADVADDR_EN only) faulting address
//   count_o..prid_o           live register contents
//   timer_int_o               timer interrupt request
//
// Optional feature macro: CP0_BADVADDR_EN adds BadVAddr (address 8) and
// AdEL/AdES exception handling.
// ----------------------------------------------------------------------------
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr_i,
`endif
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] r_count,   w_count_next;
    logic [31:0] r_compare, w_compare_next;
    logic [31:0] r_status,  w_status_next;
    logic [31:0] r_cause,   w_cause_next;
    logic [31:0] r_epc,     w_epc_next;
    logic        r_timer,   w_timer_next;
    exc_dec_t    w_exc;
`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr, w_badvaddr_next;
`endif

    assign w_exc = decode_exc(excepttype_i);

    // Next-state: increment/timer first, then mtc0 write, then exception
    // update, so later stages override earlier ones on overlapping fields.
    always_comb begin
        w_count_next   = r_count + 32'd1;
        w_compare_next = r_compare;
        w_status_next  = r_status;
        w_cause_next   = r_cause;
        w_epc_next     = r_epc;
        w_timer_next   = r_timer;
`ifdef CP0_BADVADDR_EN
        w_badvaddr_next = r_badvaddr;
`endif

        // Hardware interrupt pending bits track the pins every cycle.
        w_cause_next[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] = int_i;

        // Timer match is sticky; a zero Compare disables it.
        if ((r_compare != 32'd0) && (r_count == r_compare)) begin
            w_timer_next = 1'b1;
        end

        if (we_i) begin
            case (waddr_i)
                CP0_REG_COUNT:   w_count_next = data_i;
                CP0_REG_COMPARE: begin
                    w_compare_next = data_i;
                    w_timer_next   = 1'b0;   // acknowledges the timer, beats a same-cycle match
                end
                CP0_REG_STATUS:  w_status_next = data_i;
                CP0_REG_EPC:     w_epc_next    = data_i;
                CP0_REG_CAUSE: begin
                    w_cause_next[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] =
                        data_i[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
                    w_cause_next[CAUSE_IV] = data_i[CAUSE_IV];
                    w_cause_next[CAUSE_WP] = data_i[CAUSE_WP];
                end
                default: ;
            endcase
        end

        if (w_exc.valid) begin
            // A nested exception (EXL already set) keeps the original EPC/BD.
            if (!r_status[STATUS_EXL]) begin
                w_epc_next = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                               : current_inst_addr_i;
                w_cause_next[CAUSE_BD] = is_in_delayslot_i;
            end
            w_status_next[STATUS_EXL]                 = 1'b1;
            w_cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO]   = w_exc.code;
`ifdef CP0_BADVADDR_EN
            if ((excepttype_i == EXC_TYPE_ADEL) || (excepttype_i == EXC_TYPE_ADES)) begin
                w_badvaddr_next = badvaddr_i;
            end
`endif
        end else if (excepttype_i == EXC_TYPE_ERET) begin
            w_status_next[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_status  <= STATUS_RESET;
            r_cause   <= 32'd0;
            r_epc     <= 32'd0;
            r_timer   <= 1'b0;
`ifdef CP0_BADVADDR_EN
            r_badvaddr <= 32'd0;
`endif
        end else begin
            r_count   <= w_count_next;
            r_compare <= w_compare_next;
            r_status  <= w_status_next;
            r_cause   <= w_cause_next;
            r_epc     <= w_epc_next;
            r_timer   <= w_timer_next;
`ifdef CP0_BADVADDR_EN
            r_badvaddr <= w_badvaddr_next;
`endif
        end
    end

    // mfc0 read path: no bypass, a write shows up the cycle after.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_REG_COUNT:    data_o = r_count;
            CP0_REG_COMPARE:  data_o = r_compare;
            CP0_REG_STATUS:   data_o = r_status;
            CP0_REG_CAUSE:    data_o = r_cause;
            CP0_REG_EPC:      data_o = r_epc;
            CP0_REG_PRID:     data_o = PRID_VALUE;
            CP0_REG_CONFIG:   data_o = CONFIG_VALUE;
`ifdef CP0_BADVADDR_EN
            CP0_REG_BADVADDR: data_o = r_badvaddr;
`endif
            default:          data_o = 32'd0;
        endcase
    end

    assign count_o     = r_count;
    assign compare_o   = r_compare;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = r_timer;

endmodule
